// File: rtl/can_bit_destuffer_if.sv
// rtl/can_bit_destuffer_if.sv - CAN receive bit stream between SOF detector/parser and the destuffer
interface can_bit_destuffer_if;
  logic       can_rx;
  logic       sof_detect;
  logic       destuff_en;
  logic       frame_done;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic [7:0] rx_bit_idx;
  logic       stuff_drop;
  logic       stuff_err;
  logic       busy;

  modport master (
    output can_rx, sof_detect, destuff_en, frame_done,
    input  rx_bit, rx_bit_valid, rx_bit_idx, stuff_drop, stuff_err, busy
  );

  modport slave (
    input  can_rx, sof_detect, destuff_en, frame_done,
    output rx_bit, rx_bit_valid, rx_bit_idx, stuff_drop, stuff_err, busy
  );
endinterface

// File: rtl/can_bit_destuffer.sv
// rtl/can_bit_destuffer.sv - CAN bit timing, mid-bit sampling, resync and stuff-bit removal
module can_bit_destuffer #(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  can_bit_destuffer_if.slave bus
);

  localparam int BIT_CLKS  = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int SAMPLE_PT = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             prev_rx_q, prev_rx_d;
  logic             last_bit_q, last_bit_d;
  logic [2:0]       run_len_q, run_len_d;
  logic [7:0]       bit_idx_q, bit_idx_d;
  logic             rx_bit_q, rx_bit_d;
  logic             rx_bit_valid_q, rx_bit_valid_d;
  logic [7:0]       rx_bit_idx_q, rx_bit_idx_d;
  logic             stuff_drop_q, stuff_drop_d;
  logic             stuff_err_q, stuff_err_d;
  logic             rx_fall;
  logic             deliver;

  assign rx_fall = prev_rx_q && !bus.can_rx;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    prev_rx_d      = bus.can_rx;
    last_bit_d     = last_bit_q;
    run_len_d      = run_len_q;
    bit_idx_d      = bit_idx_q;
    rx_bit_d       = rx_bit_q;
    rx_bit_idx_d   = rx_bit_idx_q;
    rx_bit_valid_d = 1'b0;
    stuff_drop_d   = 1'b0;
    stuff_err_d    = 1'b0;
    deliver        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Count starts at 1 because the SOF pulse lags the bus edge by one clock.
        if (bus.sof_detect) begin
          state_d   = ST_RUN;
          bit_cnt_d = CNT_ONE;
          bit_idx_d = 8'd0;
          run_len_d = 3'd0;
        end
      end
      default: begin
        if (rx_fall) begin
          bit_cnt_d = CNT_ONE;
        end else if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end

        // The sample decision uses the pre-resync count, so an edge on the sample clock still samples.
        if (bus.frame_done) begin
          state_d = ST_IDLE;
        end else if (bit_cnt_q == CNT_SAMPLE) begin
          if (!bus.destuff_en) begin
            deliver   = 1'b1;
            run_len_d = 3'd0;
          end else if (run_len_q == 3'd5) begin
            if (bus.can_rx != last_bit_q) begin
              stuff_drop_d = 1'b1;
              last_bit_d   = bus.can_rx;
              run_len_d    = 3'd1;
            end else begin
              stuff_err_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end else begin
            deliver = 1'b1;
            if (bus.can_rx == last_bit_q) begin
              run_len_d = run_len_q + 3'd1;
            end else begin
              run_len_d  = 3'd1;
              last_bit_d = bus.can_rx;
            end
          end
        end
      end
    endcase

    if (deliver) begin
      rx_bit_valid_d = 1'b1;
      rx_bit_d       = bus.can_rx;
      rx_bit_idx_d   = bit_idx_q;
      if (bit_idx_q != 8'hFF) begin
        bit_idx_d = bit_idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      prev_rx_q      <= 1'b1;
      last_bit_q     <= 1'b1;
      run_len_q      <= 3'd0;
      bit_idx_q      <= 8'd0;
      rx_bit_q       <= 1'b0;
      rx_bit_valid_q <= 1'b0;
      rx_bit_idx_q   <= 8'd0;
      stuff_drop_q   <= 1'b0;
      stuff_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      prev_rx_q      <= prev_rx_d;
      last_bit_q     <= last_bit_d;
      run_len_q      <= run_len_d;
      bit_idx_q      <= bit_idx_d;
      rx_bit_q       <= rx_bit_d;
      rx_bit_valid_q <= rx_bit_valid_d;
      rx_bit_idx_q   <= rx_bit_idx_d;
      stuff_drop_q   <= stuff_drop_d;
      stuff_err_q    <= stuff_err_d;
    end
  end

  assign bus.rx_bit       = rx_bit_q;
  assign bus.rx_bit_valid = rx_bit_valid_q;
  assign bus.rx_bit_idx   = rx_bit_idx_q;
  assign bus.stuff_drop   = stuff_drop_q;
  assign bus.stuff_err    = stuff_err_q;
  assign bus.busy         = (state_q == ST_RUN);

endmodule

// File: doc/can_bit_destuffer.md
# can_bit_destuffer

Downstream neighbour of the SOF detector in the CAN receive path. On a one-cycle `sof_detect` pulse it hard-synchronises a bit-period timer and samples `can_rx` at mid-bit. It resynchronises on recessive-to-dominant edges and removes stuff bits while destuffing is enabled. Destuffed bits are delivered to the frame parser as single-cycle valid pulses with a running bit index. Stuff-rule violations are flagged.

## Interface
- `clk_speed_MHz`, 100: system clock frequency in MHz.
- `can_bit_rate_Kbits`, 1000: CAN bit rate in kbit/s.
- Derived: BIT_CLKS = clk_speed_MHz*1000/can_bit_rate_Kbits (100 at defaults); SAMPLE_PT = BIT_CLKS/2 (50).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `can_rx`  in  1  bus level, 1 = recessive; already synchronous to clk.
- `sof_detect`  in  1  one-cycle SOF pulse from the SOF detector.
- `destuff_en`  in  1  from parser; high from SOF through CRC sequence, low afterwards.
- `frame_done`  in  1  one-cycle pulse from parser; ends the frame.
- `rx_bit`  out  1  destuffed bit value; valid only when `rx_bit_valid` = 1.
- `rx_bit_valid`  out  1  one-cycle pulse per delivered bit.
- `rx_bit_idx`  out  8  index of the current `rx_bit`; SOF = 0; saturates at 255.
- `stuff_drop`  out  1  one-cycle pulse when a stuff bit is removed.
- `stuff_err`  out  1  one-cycle pulse on a sixth identical bit while `destuff_en` = 1.
- `busy`  out  1  high while state = RUN.

## Operation
- States: IDLE, RUN.
- Reset: state IDLE. All outputs 0. bit_cnt = 0, run_len = 0, last_bit = 1, prev_rx = 1.
- IDLE:
  - `sof_detect` = 1 -> RUN, bit_cnt <= 1 (compensates the detector's one-cycle latency), bit_idx internal <= 0, run_len <= 0.
  - All other inputs are ignored.
- RUN, bit timer:
  - bit_cnt increments each clk and wraps from BIT_CLKS-1 to 0.
  - Sample point is the edge where bit_cnt == SAMPLE_PT-1; `can_rx` is captured there.
- RUN, resync:
  - prev_rx <= can_rx every cycle.
  - `can_rx` = 0 and prev_rx = 1 -> bit_cnt <= 1.
  - If this coincides with the sample point, the sample is still taken with the pre-resync count.
- Destuff, per sample b with `destuff_en` = 1:
  - run_len == 5 and b != last_bit: stuff bit. Drop it, pulse `stuff_drop`, last_bit <= b, run_len <= 1; no `rx_bit_valid`.
  - run_len == 5 and b == last_bit: pulse `stuff_err`, go to IDLE; no `rx_bit_valid`.
  - Otherwise: deliver b. If b == last_bit, run_len++; else run_len <= 1 and last_bit <= b.
  - The SOF sample starts with run_len = 0, so it is always delivered, leaving run_len = 1 and last_bit = 0.
- Per sample with `destuff_en` = 0: always deliver b; no stuff checks; run_len <= 0.
- Delivery: `rx_bit` <= b, `rx_bit_idx` <= bit_idx, then bit_idx increments, saturating at 255.
- `frame_done` in RUN -> IDLE next cycle; a sample in the same cycle is discarded.
- `sof_detect` in RUN is ignored.
- `frame_done` in IDLE is ignored.

## Timing
- Latency: `rx_bit_valid`, `stuff_drop` and `stuff_err` assert on the clk after the sample-point edge (registered outputs). At defaults this is ~50 clks after the bit's falling/start edge.
- `rx_bit` and `rx_bit_idx` hold their value until the next delivery.
- `stuff_err` and `stuff_drop` are mutually exclusive with `rx_bit_valid` in any cycle.
- `busy` drops on the same edge that enters IDLE, including the `stuff_err` cycle.
- Reset mid-frame: all state and outputs return to reset values immediately; there is no pulse on release.
- Width: bit_cnt uses clog2(BIT_CLKS) bits; run_len uses 3 bits.

## Test plan
- Reset, then a `sof_detect` pulse with `can_rx` held 0 for 1 bit, then 1: one pulse with `rx_bit` = 0, idx 0, ~50 clks after SOF. Next bit delivers `rx_bit` = 1, idx 1, 100 clks later.
- SOF plus dominant bits 0,0,0,0 (5 dominant total), then a 1 stuff bit, then 1, with `destuff_en` = 1: idx 0..4 = 0. `stuff_drop` pulses once. Next delivered bit is 1 with idx 5.
- Six consecutive recessive bits after a dominant run, with `destuff_en` = 1: `stuff_err` pulse at the sixth sample, `busy` -> 0, no sixth `rx_bit_valid`.
- Same six recessive bits with `destuff_en` = 0: six deliveries, no `stuff_err`, no `stuff_drop`.
- Falling edge arriving 10 clks early, i.e. bit length 90: next sample lands 49 clks after the new edge; bit value is correct.
- `frame_done` mid-frame, then a second `sof_detect`: `busy` drops. The new frame restarts at idx 0.
- Assert `rst_n` low during RUN: `busy`, `rx_bit_valid` and `rx_bit_idx` go to 0 asynchronously.
